regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth SHALL be 2**ADDR_W registers.
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes and reserves.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- rs, in, ADDR_W, read port A address.
- rt, in, ADDR_W, read port B address.
- write_reg, in, ADDR_W, write address.
- RegWrite, in, 1, write enable.
- write_data, in, DATA_W, write data.
- reserve_reg, in, ADDR_W, address to mark pending.
- Reserve, in, 1, reserve enable.
- a, out, DATA_W, read data A.
- b, out, DATA_W, read data B.
- a_busy, out, 1, register rs has a pending producer.
- b_busy, out, 1, register rt has a pending producer.
- stall, out, 1, equals a_busy OR b_busy.
- busy_count, out, ADDR_W+1, number of registers currently marked busy.

Function
REQ-003 Storage SHALL be 2**ADDR_W registers of DATA_W bits, plus one busy bit per register.
REQ-004 When RegWrite=1 at a rising clk edge, the block SHALL write write_data into register write_reg; that edge SHALL also clear busy[write_reg].
REQ-005 With ZERO_REG=1, writes and reserves to address 0 SHALL be ignored, reads of address 0 SHALL return 0, and busy[0] SHALL stay 0.
REQ-006 Reads SHALL be combinational, with zero cycles of latency from rs or rt to a or b.
REQ-007 Write bypass: when RegWrite=1 and write_reg equals rs (and the ZERO_REG exclusion does not apply), a SHALL equal write_data in the same cycle; the same rule SHALL apply to rt and b.
REQ-008 a_busy SHALL be busy[rs] AND NOT (RegWrite AND write_reg equals rs); b_busy SHALL follow the same rule for rt.
REQ-009 When Reserve=1 at a rising clk edge, the block SHALL set busy[reserve_reg].
REQ-010 If Reserve and RegWrite target the same register on the same edge, the data SHALL be written and busy SHALL end set, because the reserve wins.
REQ-011 Reserving an already-busy register SHALL leave it busy and SHALL leave busy_count unchanged.
REQ-012 Writing a non-busy register SHALL leave its busy bit at 0.
REQ-013 busy_count SHALL be registered and SHALL equal the population count of the busy bits after each edge.
- Per edge it SHALL change by -1, 0 or +1 only.
- The value SHALL never exceed 2**ADDR_W (2**ADDR_W-1 when ZERO_REG=1).
REQ-014 A read of a busy register SHALL still return the stored (stale) value; the consumer SHALL use stall to qualify it.
REQ-015 When RegWrite=0 and Reserve=0, state SHALL hold unchanged.

Reset
REQ-016 Asserting rst SHALL immediately, without waiting for clk, clear every register to 0, every busy bit to 0, and busy_count to 0.
REQ-017 While rst=1, writes and reserves SHALL be ignored; a, b, a_busy, b_busy, stall SHALL all read 0.
REQ-018 Asserting rst mid-operation (with busy bits set) SHALL discard all pending reservations.
REQ-019 The first write or reserve after reset SHALL take effect on the first rising edge at which rst=0.

Verification
REQ-020 The bench SHALL cover the following scenarios, with defaults DATA_W=32, ADDR_W=5, ZERO_REG=1:
- Write 0x0000_0005 to r3, then set rs=3 -> a=0x0000_0005 the following cycle, and a_busy=0.
- RegWrite=1, write_reg=7, write_data=0xDEAD_BEEF, with rs=7 in the same cycle -> a=0xDEAD_BEEF combinationally before the edge.
- Reserve r4, then set rt=4 next cycle -> b_busy=1, stall=1, busy_count=1; write r4=0x11 -> bypass gives b_busy=0 in the write cycle, and after the edge busy_count=0.
- Reserve and write r9 on the same edge -> r9 holds the new data, busy[9]=1, busy_count increments by 1.
- Write 0xFFFF_FFFF to r0 and reserve r0 -> a=0 with rs=0, a_busy=0, busy_count unchanged.
- Reserve r1, r2, r5, then assert rst asynchronously mid-cycle -> busy_count=0, stall=0 and all registers 0 before the next clk edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Register file with two combinational read ports, one write port with
//            same-cycle bypass, and a per-register busy scoreboard for hazard stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] reserve_reg,
    input  logic              Reserve,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              a_busy,
    output logic              b_busy,
    output logic              stall,
    output logic [ADDR_W:0]   busy_count
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [c_DEPTH];
    logic [DATA_W-1:0] regs_d [c_DEPTH];
    logic [c_DEPTH-1:0] busy_q;
    logic [c_DEPTH-1:0] busy_d;
    logic [ADDR_W:0]    busy_count_q;
    logic [ADDR_W:0]    busy_count_d;

    // One bit per register: 0 marks the hardwired-zero register.
    logic [c_DEPTH-1:0] w_writable;

    logic w_wr_en;
    logic w_rsv_en;
    logic w_bypass_a;
    logic w_bypass_b;

    generate
        if (ZERO_REG != 0) begin : g_zero_reg
            assign w_writable = {{(c_DEPTH-1){1'b1}}, 1'b0};
        end else begin : g_no_zero_reg
            assign w_writable = {c_DEPTH{1'b1}};
        end
    endgenerate

    assign w_wr_en    = RegWrite && w_writable[write_reg];
    assign w_rsv_en   = Reserve  && w_writable[reserve_reg];
    assign w_bypass_a = w_wr_en && (write_reg == rs);
    assign w_bypass_b = w_wr_en && (write_reg == rt);

    // Reserve is applied after the write so it wins on a same-register collision.
    always_comb begin
        regs_d       = regs_q;
        busy_d       = busy_q;
        busy_count_d = '0;
        if (w_wr_en) begin
            regs_d[write_reg] = write_data;
            busy_d[write_reg] = 1'b0;
        end
        if (w_rsv_en) begin
            busy_d[reserve_reg] = 1'b1;
        end
        for (int i = 0; i < c_DEPTH; i++) begin
            busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Outputs are forced quiet while reset is held, including the bypass path.
    always_comb begin
        a      = '0;
        b      = '0;
        a_busy = 1'b0;
        b_busy = 1'b0;
        if (!rst) begin
            if (w_bypass_a) begin
                a = write_data;
            end else if (w_writable[rs]) begin
                a = regs_q[rs];
            end
            if (w_bypass_b) begin
                b = write_data;
            end else if (w_writable[rt]) begin
                b = regs_q[rt];
            end
            a_busy = busy_q[rs] && !w_bypass_a;
            b_busy = busy_q[rt] && !w_bypass_b;
        end
    end

    assign stall      = a_busy || b_busy;
    assign busy_count = busy_count_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed self-checking bench for regfile_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] write_reg;
    logic              RegWrite;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] reserve_reg;
    logic              Reserve;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              a_busy;
    logic              b_busy;
    logic              stall;
    logic [ADDR_W:0]   busy_count;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs         (rs),
        .rt         (rt),
        .write_reg  (write_reg),
        .RegWrite   (RegWrite),
        .write_data (write_data),
        .reserve_reg(reserve_reg),
        .Reserve    (Reserve),
        .a          (a),
        .b          (b),
        .a_busy     (a_busy),
        .b_busy     (b_busy),
        .stall      (stall),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0;
        Reserve  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rs = '0; rt = '0; write_reg = '0; RegWrite = 1'b0;
        write_data = '0; reserve_reg = '0; Reserve = 1'b0;
        #12;
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_count", busy_count, 0);
        check("rst_stall", stall, 0);

        // First write after reset lands on the first edge with rst low.
        @(negedge clk);
        rst = 1'b0;
        RegWrite = 1'b1; write_reg = 5'd3; write_data = 32'h0000_0005;
        step();
        idle();
        rs = 5'd3;
        #1;
        check("r3_read", a, 32'h0000_0005);
        check("r3_a_busy", a_busy, 0);

        // Same-cycle bypass, then the stored value.
        RegWrite = 1'b1; write_reg = 5'd7; write_data = 32'hDEAD_BEEF; rs = 5'd7;
        #1;
        check("bypass_a", a, 32'hDEAD_BEEF);
        step();
        idle();
        #1;
        check("r7_stored", a, 32'hDEAD_BEEF);

        // Reserve r4, observe stall, then clear it with a write.
        Reserve = 1'b1; reserve_reg = 5'd4;
        step();
        idle();
        rt = 5'd4;
        #1;
        check("r4_b_busy", b_busy, 1);
        check("r4_stall", stall, 1);
        check("r4_count", busy_count, 1);
        check("r4_stale", b, 0);
        RegWrite = 1'b1; write_reg = 5'd4; write_data = 32'h0000_0011;
        #1;
        check("r4_bypass_busy", b_busy, 0);
        check("r4_bypass_data", b, 32'h0000_0011);
        check("r4_bypass_stall", stall, 0);
        step();
        idle();
        #1;
        check("r4_count_clr", busy_count, 0);
        check("r4_data", b, 32'h0000_0011);

        // Reserve and write the same register: data written, busy wins.
        RegWrite = 1'b1; write_reg = 5'd9; write_data = 32'hCAFE_F00D;
        Reserve = 1'b1; reserve_reg = 5'd9; rs = 5'd9;
        #1;
        check("r9_bypass", a, 32'hCAFE_F00D);
        check("r9_pre_busy", a_busy, 0);
        step();
        idle();
        #1;
        check("r9_data", a, 32'hCAFE_F00D);
        check("r9_busy", a_busy, 1);
        check("r9_count", busy_count, 1);

        // Re-reserving a busy register leaves the count alone.
        Reserve = 1'b1; reserve_reg = 5'd9;
        step();
        idle();
        #1;
        check("r9_rereserve_count", busy_count, 1);

        // Register 0 ignores writes and reserves.
        RegWrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
        Reserve = 1'b1; reserve_reg = 5'd0; rs = 5'd0;
        #1;
        check("r0_bypass", a, 0);
        step();
        idle();
        #1;
        check("r0_read", a, 0);
        check("r0_busy", a_busy, 0);
        check("r0_count", busy_count, 1);

        // Build up several reservations, then reset mid-cycle.
        Reserve = 1'b1; reserve_reg = 5'd1;
        step();
        reserve_reg = 5'd2;
        step();
        reserve_reg = 5'd5;
        step();
        idle();
        rs = 5'd1; rt = 5'd7;
        #1;
        check("multi_count", busy_count, 4);
        check("multi_stall", stall, 1);
        #2;
        rst = 1'b1;
        RegWrite = 1'b1; write_reg = 5'd3; write_data = 32'h0000_0055; rs = 5'd3;
        #1;
        check("arst_count", busy_count, 0);
        check("arst_stall", stall, 0);
        check("arst_a", a, 0);
        check("arst_b", b, 0);
        step();
        idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_count", busy_count, 0);
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            rs = i[ADDR_W-1:0];
            rt = i[ADDR_W-1:0];
            #0.1;
            check($sformatf("post_rst_reg%0d", i), a, 0);
            check($sformatf("post_rst_busy%0d", i), b_busy, 0);
        end

        // Write after reset takes effect on the next edge.
        RegWrite = 1'b1; write_reg = 5'd3; write_data = 32'h0000_0077; rs = 5'd12;
        step();
        idle();
        rs = 5'd3;
        #1;
        check("post_rst_write", a, 32'h0000_0077);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
